// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Access-type codes, FSM states and lane helpers for the LSU M-stage
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

  localparam int LSU_XLEN = 64;

  // Load codes use all three funct3 bits
  localparam logic [2:0] RW_LB  = 3'b000;
  localparam logic [2:0] RW_LH  = 3'b001;
  localparam logic [2:0] RW_LW  = 3'b010;
  localparam logic [2:0] RW_LD  = 3'b011;
  localparam logic [2:0] RW_LBU = 3'b100;
  localparam logic [2:0] RW_LHU = 3'b101;
  localparam logic [2:0] RW_LWU = 3'b110;

  // Store codes only look at the size bits
  localparam logic [1:0] RW_SB = 2'b00;
  localparam logic [1:0] RW_SH = 2'b01;
  localparam logic [1:0] RW_SW = 2'b10;
  localparam logic [1:0] RW_SD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      RW_SB:   m = 8'h01;
      RW_SH:   m = 8'h03;
      RW_SW:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      RW_SB:   m = 3'b000;
      RW_SH:   m = 3'b001;
      RW_SW:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_load_align
// Brief  : Shift raw doubleword to the byte offset, truncate, sign/zero extend
// Rev    : 1.0
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_off,
  input  logic [2:0]      i_rw_type,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] shifted;

  assign shifted = i_raw >> {i_off, 3'b000};

  always_comb begin
    o_data = shifted;
    case (i_rw_type)
      RW_LB:   o_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      RW_LH:   o_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      RW_LW:   o_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      RW_LBU:  o_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      RW_LHU:  o_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      RW_LWU:  o_data = {{(XLEN-32){1'b0}},        shifted[31:0]};
      RW_LD:   o_data = shifted;
      default: o_data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_stage
// Brief  : M-stage load/store responder on a valid/ready 64-bit data port.
//          Define LSU_POSTED_WRITE_EN to retire stores on request acceptance.
// Rev    : 1.0
// ============================================================================
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN   = LSU_XLEN,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [2:0]        RW_typeM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [XLEN-1:0]   wdataM,
  output logic [XLEN-1:0]   rdataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_wstrb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic              we_q, we_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              op;
  logic              is_store;
  logic              misaligned;
  logic [7:0]        wstrb_new;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   load_data;

  // A simultaneous read and write request is serviced as a read
  assign op         = memreadM | memwriteM;
  assign is_store   = memwriteM & ~memreadM;
  assign misaligned = |(addrM[2:0] & align_mask(RW_typeM[1:0]));
  assign wstrb_new  = size_mask(RW_typeM[1:0]) << addrM[2:0];

  always_comb begin
    wdata_rep = wdataM;
    case (RW_typeM[1:0])
      RW_SB:   wdata_rep = {(XLEN/8){wdataM[7:0]}};
      RW_SH:   wdata_rep = {(XLEN/16){wdataM[15:0]}};
      RW_SW:   wdata_rep = {(XLEN/32){wdataM[31:0]}};
      RW_SD:   wdata_rep = wdataM;
      default: wdata_rep = wdataM;
    endcase
  end

  lsu_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .i_raw    (dmem_rdata),
    .i_off    (addr_q[2:0]),
    .i_rw_type(type_q),
    .o_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    misalignM = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          if (misaligned) begin
            misalignM = 1'b1;
            if (memreadM) begin
              rdata_d = '0;
            end
          end else begin
            addr_d  = addrM;
            type_d  = RW_typeM;
            we_d    = is_store;
            wstrb_d = wstrb_new;
            wdata_d = wdata_rep;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
`ifdef LSU_POSTED_WRITE_EN
          state_d = we_q ? DONE : WAIT;
`else
          state_d = WAIT;
`endif
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          // Store acks leave the last load result untouched
          if (!we_q) begin
            rdata_d = load_data;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stallM         = op & ~misaligned & (state_q != DONE);
  assign rdataM         = rdata_q;
  assign dmem_req_valid = (state_q == REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_wstrb     = wstrb_q;
  assign dmem_wdata     = wdata_q;

endmodule
`default_nettype wire
